result_writeback_ctrl: RTL and testbench

- Drains a finished layer's output words from the local result memory to system memory.
- Reads words from the local result memory through its read-enable/data interface and issues one bus write per word on a valid/ready write-request channel.
- Sits between the local result memory and the system bus master, and is kicked by the layer controller once the layer's results are complete.
- Reports busy while running and pulses done when the last word has been accepted.

---
 rtl/result_writeback_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_result_writeback_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// result_writeback_ctrl
//
// Drains a finished layer's output words from the local result memory to
// system memory. Each word is read from the local memory, captured one cycle
// later, and then offered as a single bus write until the bus accepts it.
// Only one local read is in flight at a time, so a word costs three cycles
// when the bus never stalls.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous, active-high reset
//   start               begin a transfer (sampled only while idle)
//   base_addr           destination byte address of word 0 (latched on start)
//   word_count          number of words to move (latched on start)
//   busy                high whenever a transfer is in progress
//   done                one-cycle pulse after the last word is accepted
//   read_result_signal  read enable to the local result memory
//   read_result_addr    local word address (word index modulo 2^LOCAL_AW)
//   read_result_data    local read data, valid the cycle after the read
//   wr_valid            bus write request valid
//   wr_addr             bus write byte address
//   wr_data             bus write data
//   wr_ready            bus accepts the request when wr_valid && wr_ready
// -----------------------------------------------------------------------------
module result_writeback_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 16,
  parameter int LOCAL_AW = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    word_count,
  output logic                busy,
  output logic                done,
  output logic                read_result_signal,
  output logic [LOCAL_AW-1:0] read_result_addr,
  input  logic [DATA_W-1:0]   read_result_data,
  output logic                wr_valid,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  input  logic                wr_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CAP  = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [LEN_W-1:0]    index_q;
  logic [LEN_W-1:0]    count_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   data_q;

  logic                handshake;
  logic                last_word;

  // Byte address of word idx: base + idx*4, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_byte_addr(
    input logic [ADDR_W-1:0] base,
    input logic [LEN_W-1:0]  idx
  );
    logic [ADDR_W-1:0] idx_ext;
    idx_ext = ADDR_W'(idx);
    return base + (idx_ext << 2);
  endfunction

  assign handshake = (state == S_SEND) && wr_ready;
  // count_q is never zero outside IDLE/DONE, so count_q-1 does not underflow
  // in the states where this is used.
  assign last_word = (index_q == (count_q - LEN_W'(1)));

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // The count is being latched in this same cycle, so decide on the
        // live input value.
        if (start) begin
          state_nxt = (word_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: state_nxt = S_CAP;
      S_CAP:  state_nxt = S_SEND;
      S_SEND: begin
        if (handshake) begin
          state_nxt = last_word ? S_DONE : S_READ;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- output logic ----
  // Outputs decode the state register directly, so an asynchronous reset
  // drops every request at once without waiting for a clock edge.
  always_comb begin
    busy               = 1'b0;
    done               = 1'b0;
    read_result_signal = 1'b0;
    read_result_addr   = '0;
    wr_valid           = 1'b0;
    wr_addr            = '0;
    wr_data            = '0;
    case (state)
      S_READ: begin
        busy               = 1'b1;
        read_result_signal = 1'b1;
        read_result_addr   = index_q[LOCAL_AW-1:0];
      end
      S_CAP: begin
        busy = 1'b1;
      end
      S_SEND: begin
        // Everything here comes from registers that are frozen while in
        // SEND, so the request stays stable under backpressure.
        busy     = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = word_byte_addr(base_q, index_q);
        wr_data  = data_q;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---- transfer bookkeeping and data capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= '0;
      count_q <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= word_count;
            index_q <= '0;
          end
        end
        S_CAP: begin
          data_q <= read_result_data;
        end
        S_SEND: begin
          if (handshake && !last_word) begin
            index_q <= index_q + LEN_W'(1);
          end
        end
        default: begin
          index_q <= index_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_writeback_ctrl.sv
module tb_result_writeback_ctrl;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 16;
  localparam int LOCAL_AW = 10;
  localparam int MEM_N    = 1 << LOCAL_AW;

  logic                clk;
  logic                rst;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [LEN_W-1:0]    word_count;
  logic                busy;
  logic                done;
  logic                read_result_signal;
  logic [LOCAL_AW-1:0] read_result_addr;
  logic [DATA_W-1:0]   read_result_data;
  logic                wr_valid;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_ready;

  int n_tests;
  int n_failed;

  logic [DATA_W-1:0] mem [0:MEM_N-1];

  result_writeback_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .LOCAL_AW(LOCAL_AW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .read_result_signal(read_result_signal),
    .read_result_addr  (read_result_addr),
    .read_result_data  (read_result_data),
    .wr_valid          (wr_valid),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_ready          (wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Local result memory: one-cycle read latency.
  always @(posedge clk) begin
    if (read_result_signal) read_result_data <= mem[read_result_addr];
  end

  typedef struct {
    logic [31:0] base;
    logic [15:0] cnt;
    int          stall_word;
    int          stall_len;
    bit          change_mid;
    int          exp_wr;
    int          exp_done;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_rd"},     read_result_signal, 0);
    check({tag, "_rdaddr"}, read_result_addr, 0);
    check({tag, "_wrv"},    wr_valid, 0);
    check({tag, "_wraddr"}, wr_addr, 0);
    check({tag, "_wrdata"}, wr_data, 0);
  endtask

  // Runs one transfer starting in the current cycle (cycle 0) and checks
  // every read and write against the memory model as it happens.
  task automatic run_xfer(input logic [31:0] base, input logic [15:0] cnt,
                          input int stall_word, input int stall_len, input bit change_mid,
                          output int n_wr, output int n_rd, output int done_cyc,
                          output int n_done, output logic [31:0] last_addr);
    int          stall_left;
    bit          prev_stall;
    bit          finished;
    logic [31:0] pa;
    logic [31:0] pd;
    logic [31:0] exp_a;
    n_wr = 0; n_rd = 0; done_cyc = -1; n_done = 0; last_addr = 32'h0;
    stall_left = stall_len; prev_stall = 0; finished = 0; pa = '0; pd = '0;
    start = 1'b1; base_addr = base; word_count = cnt; wr_ready = 1'b1;
    for (int cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (change_mid && cyc == 2) begin
        start = 1'b1; word_count = 16'd9; base_addr = 32'hDEAD_0000;
      end
      check("busy_run", busy, 1);
      if (read_result_signal) begin
        check("rd_addr", read_result_addr, n_rd % MEM_N);
        check("rd_excl", wr_valid, 0);
        if (stall_len == 0) check("rd_cycle", cyc, 1 + 3 * n_rd);
        n_rd++;
      end
      if (wr_valid) begin
        if (prev_stall) begin
          check("hold_addr", wr_addr, pa);
          check("hold_data", wr_data, pd);
        end
        if (n_wr == stall_word && stall_left > 0) begin
          wr_ready = 1'b0; stall_left--; prev_stall = 1; pa = wr_addr; pd = wr_data;
        end else begin
          wr_ready = 1'b1; prev_stall = 0;
          exp_a = base + 32'(n_wr) * 32'd4;
          check("wr_addr", wr_addr, exp_a);
          check("wr_data", wr_data, mem[n_wr % MEM_N]);
          if (stall_len == 0) check("wr_cycle", cyc, 3 + 3 * n_wr);
          last_addr = wr_addr;
          n_wr++;
        end
      end else begin
        wr_ready = 1'b1;
      end
      if (done) begin
        n_done++; done_cyc = cyc; finished = 1;
      end
    end
    if (!finished) check("timeout_done", 0, 1);
    // A few trailing cycles: must be idle, with no second pulse or write.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
      if (wr_valid) n_wr++;
      if (read_result_signal) n_rd++;
    end
    check("busy_after", busy, 0);
  endtask

  initial begin
    int          n_wr, n_rd, done_cyc, n_done;
    logic [31:0] last_addr;
    bit          seen;
    n_tests = 0; n_failed = 0;
    for (int i = 0; i < MEM_N; i++) mem[i] = 32'hA0 + i;

    vecs[0] = '{32'h0000_1000, 16'd3,    -1, 0, 1'b0, 3,    10,   32'h0000_1008};
    vecs[1] = '{32'h0000_1000, 16'd3,     1, 4, 1'b0, 3,    14,   32'h0000_1008};
    vecs[2] = '{32'h0000_2000, 16'd0,    -1, 0, 1'b0, 0,    1,    32'h0000_0000};
    vecs[3] = '{32'h0000_1000, 16'd3,    -1, 0, 1'b1, 3,    10,   32'h0000_1008};
    vecs[4] = '{32'hFFFF_FFF8, 16'd3,    -1, 0, 1'b0, 3,    10,   32'h0000_0000};
    vecs[5] = '{32'h0000_0040, 16'd1,    -1, 0, 1'b0, 1,    4,    32'h0000_0040};
    vecs[6] = '{32'h0000_0000, 16'd1026, -1, 0, 1'b0, 1026, 3079, 32'h0000_1004};

    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; wr_ready = 1'b1;
    #1;
    check_idle_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      run_xfer(vecs[v].base, vecs[v].cnt, vecs[v].stall_word, vecs[v].stall_len,
               vecs[v].change_mid, n_wr, n_rd, done_cyc, n_done, last_addr);
      check($sformatf("v%0d_writes", v), n_wr, vecs[v].exp_wr);
      check($sformatf("v%0d_reads", v), n_rd, vecs[v].exp_wr);
      check($sformatf("v%0d_done_cyc", v), done_cyc, vecs[v].exp_done);
      check($sformatf("v%0d_done_cnt", v), n_done, 1);
      check($sformatf("v%0d_last_addr", v), last_addr, vecs[v].exp_last);
    end

    // Reset in the middle of a transfer while a write is pending.
    start = 1'b1; base_addr = 32'h0000_3000; word_count = 16'd3; wr_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (wr_valid) seen = 1;
    end
    check("midrst_reach_send", seen, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("midrst_no_done", done, 0);
    end
    rst = 1'b0;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    run_xfer(32'h0000_5000, 16'd1, -1, 0, 1'b0, n_wr, n_rd, done_cyc, n_done, last_addr);
    check("postrst_writes", n_wr, 1);
    check("postrst_done_cyc", done_cyc, 4);
    check("postrst_done_cnt", n_done, 1);
    check("postrst_addr", last_addr, 32'h0000_5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
